// File: rtl/branch_pred_unit.sv
// Fetch PC generator with a direct-mapped BTB and 2-bit bimodal counters,
// plus the Execute-stage branch/jump resolver that flushes and redirects fetch.
module branch_pred_unit #(
  parameter int              DPW       = 32,
  parameter int              BHT_DEPTH = 64,
  parameter logic [DPW-1:0]  RESET_PC  = '0
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           stallF_i,
  output logic [DPW-1:0] PCF_o,
  output logic           pred_takenF_o,
  output logic [DPW-1:0] pred_targetF_o,
  input  logic           validE_i,
  input  logic           branchE_i,
  input  logic           jumpE_i,
  input  logic           jalrE_i,
  input  logic [2:0]     funct3E_i,
  input  logic [DPW-1:0] PCE_i,
  input  logic [DPW-1:0] immextE_i,
  input  logic [DPW-1:0] rs1E_i,
  input  logic [DPW-1:0] rs2E_i,
  input  logic           pred_takenE_i,
  input  logic [DPW-1:0] pred_targetE_i,
  output logic           flushE_o,
  output logic [DPW-1:0] redirect_pcE_o,
  output logic [DPW-1:0] linkE_o,
  output logic [DPW-1:0] mispredict_cnt_o
);

  localparam int IDX_W = $clog2(BHT_DEPTH);
  localparam int TAG_W = DPW - IDX_W - 2;

  logic             valid_q   [BHT_DEPTH];
  logic [1:0]       ctr_q     [BHT_DEPTH];
  logic [TAG_W-1:0] tag_q     [BHT_DEPTH];
  logic [DPW-1:0]   target_q  [BHT_DEPTH];
  logic             is_jump_q [BHT_DEPTH];

  logic [DPW-1:0] pcf_q, cnt_q;

  // Fetch-side lookup
  logic [IDX_W-1:0] idx_f;
  logic [TAG_W-1:0] tag_f;
  logic             hit_f;
  logic [DPW-1:0]   pcf_plus4;

  assign idx_f          = pcf_q[IDX_W+1:2];
  assign tag_f          = pcf_q[DPW-1:IDX_W+2];
  assign hit_f          = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
  assign pcf_plus4      = pcf_q + DPW'(4);
  assign pred_takenF_o  = hit_f && (is_jump_q[idx_f] || ctr_q[idx_f][1]);
  assign pred_targetF_o = pred_takenF_o ? target_q[idx_f] : pcf_plus4;
  assign PCF_o          = pcf_q;

  // Execute-side resolution
  logic             cond_e, taken_e, ctl_e, hit_e;
  logic [DPW-1:0]   target_e, pce_plus4;
  logic [IDX_W-1:0] idx_e;
  logic [TAG_W-1:0] tag_e;
  logic [1:0]       ctr_upd;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    cond_e = 1'b0;
    case (funct3E_i)
      3'b000:  cond_e = (rs1E_i == rs2E_i);
      3'b001:  cond_e = (rs1E_i != rs2E_i);
      3'b100:  cond_e = ($signed(rs1E_i) <  $signed(rs2E_i));
      3'b101:  cond_e = ($signed(rs1E_i) >= $signed(rs2E_i));
      3'b110:  cond_e = (rs1E_i <  rs2E_i);
      3'b111:  cond_e = (rs1E_i >= rs2E_i);
      default: cond_e = 1'b0;
    endcase
  end

  assign pce_plus4      = PCE_i + DPW'(4);
  assign target_e       = jalrE_i ? ((rs1E_i + immextE_i) & ~DPW'(1)) : (PCE_i + immextE_i);
  assign taken_e        = validE_i && (jumpE_i || jalrE_i || (branchE_i && cond_e));
  assign ctl_e          = validE_i && (branchE_i || jumpE_i || jalrE_i);
  assign flushE_o       = validE_i && ((taken_e != pred_takenE_i) ||
                                       (taken_e && (target_e != pred_targetE_i)));
  assign redirect_pcE_o = taken_e ? target_e : pce_plus4;
  assign linkE_o        = pce_plus4;
  assign mispredict_cnt_o = cnt_q;

  assign idx_e = PCE_i[IDX_W+1:2];
  assign tag_e = PCE_i[DPW-1:IDX_W+2];
  assign hit_e = valid_q[idx_e] && (tag_q[idx_e] == tag_e);

  always_comb begin
    ctr_upd = ctr_q[idx_e];
    if (taken_e) begin
      if (ctr_upd != 2'b11) ctr_upd = ctr_upd + 2'd1;
    end else if (ctr_upd != 2'b00) begin
      ctr_upd = ctr_upd - 2'd1;
    end
  end

  logic ctr_we, alias_clr;
  assign ctr_we    = ctl_e && branchE_i && (hit_e || taken_e);
  assign alias_clr = validE_i && !ctl_e && pred_takenE_i;

  // NOTE: only valid/ctr and the PC/counter need reset; tag/target are don't-care until valid is set.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pcf_q <= RESET_PC;
      cnt_q <= '0;
      for (int i = 0; i < BHT_DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
    end else begin
      if (flushE_o)      pcf_q <= redirect_pcE_o;
      else if (!stallF_i) pcf_q <= pred_targetF_o;

      if (flushE_o && (cnt_q != '1)) cnt_q <= cnt_q + DPW'(1);

      if (ctr_we) ctr_q[idx_e] <= hit_e ? ctr_upd : 2'b10;

      if (taken_e)        valid_q[idx_e] <= 1'b1;
      else if (alias_clr) valid_q[idx_e] <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni && taken_e) begin
      tag_q[idx_e]     <= tag_e;
      target_q[idx_e]  <= target_e;
      is_jump_q[idx_e] <= jumpE_i || jalrE_i;
    end
  end

endmodule
